// File: rtl/hex_count_pkg.sv
// Shared types and helpers for the HEX display counter source.
package hex_count_pkg;

    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {SPD_FAST, SPD_1HZ, SPD_HALF, SPD_QUARTER} speed_t;

    // Clock cycles between advances for a given rate select.
    function automatic int period(speed_t spd, int clk_hz);
        case (spd)
            SPD_FAST: return 1;
            SPD_1HZ:  return clk_hz;
            SPD_HALF: return 2 * clk_hz;
            default:  return 4 * clk_hz;
        endcase
    endfunction

endpackage

// File: rtl/hex_count_source_rate_divider.sv
// Down-counting rate divider; strobes Advance once per selected period.
module rate_divider
    import hex_count_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic   Clock,
    input  logic   Reset,
    input  logic   Enable,
    input  speed_t Speed,
    input  logic   Reload,
    output logic   Advance
);

    localparam int DW = $clog2(4 * CLK_HZ);

    logic [DW-1:0] div;
    logic [DW-1:0] reload_val;
    speed_t        speed_q;

    assign reload_val = DW'(period(Speed, CLK_HZ) - 1);

    // A pending rate change swallows the advance so the new period starts clean.
    assign Advance = Enable && !Reload && (speed_q == Speed) && (div == '0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div     <= '0;
            speed_q <= SPD_FAST;
        end else if (Reload) begin
            div     <= reload_val;
            speed_q <= Speed;
        end else if (Enable) begin
            if (speed_q != Speed) begin
                speed_q <= Speed;
                div     <= reload_val;
            end else if (div == '0) begin
                div <= reload_val;
            end else begin
                div <= div - DW'(1);
            end
        end
    end

endmodule

// File: rtl/hex_count_source.sv
// 4-digit hex up/down counter with selectable rate, parallel load and status pulses.
module hex_count_source
    import hex_count_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enable,
    input  logic [1:0]         Speed,
    input  logic               Up,
    input  logic               Load,
    input  logic [COUNT_W-1:0] LoadValue,
    output logic [COUNT_W-1:0] Count,
    output logic               Tick,
    output logic               Wrap
);

    logic advance;

    rate_divider #(.CLK_HZ(CLK_HZ)) u_div (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (Enable),
        .Speed  (speed_t'(Speed)),
        .Reload (Load),
        .Advance(advance)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
            Tick  <= 1'b0;
            Wrap  <= 1'b0;
        end else if (Load) begin
            Count <= LoadValue;
            Tick  <= 1'b0;
            Wrap  <= 1'b0;
        end else if (advance) begin
            Count <= Up ? Count + COUNT_W'(1) : Count - COUNT_W'(1);
            Tick  <= 1'b1;
            // Wrap judged on the value being left, not the one arriving.
            Wrap  <= Up ? (Count == '1) : (Count == '0);
        end else begin
            Tick <= 1'b0;
            Wrap <= 1'b0;
        end
    end

endmodule
